// File: rtl/uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sipo
// Description : UART receive deserializer. It has a 2-FF rx synchronizer, a
//               start-bit glitch filter, mid-bit sampling of 8 data bits
//               (MSB first) and a stop-bit check. It produces one byte and a
//               one-cycle status pulse per frame.
//               Optional macro UART_RX_PARITY_EN adds an even-parity bit
//               between the data bits and the stop bit, and adds the
//               parity_error output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sipo #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       busy
);

  // Offset from the synchronized start edge to the first sample point.
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int c_CNT_W  = $clog2(CLKS_PER_BIT);

  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(HALF_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd5,
`endif
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic               rx_meta_q;
  logic               rx_s_q;
  state_t             state_q,  state_d;
  logic [c_CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]         idx_q,    idx_d;
  logic [7:0]         shift_q,  shift_d;
  logic [7:0]         dout_q,   dout_d;
  logic               valid_q,  valid_d;
  logic               ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
  logic               par_q,    par_d;
  logic               perr_q,   perr_d;
`endif

  // Two-flop synchronizer for the asynchronous rx line; it idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic: bit timing, sampling and frame checks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) begin
          // The cycle in which rx_s was first seen low is the first count
          // of the start bit. This places the check HALF_BIT cycles after
          // rx_s fell.
          state_d = S_START;
          cnt_d   = c_CNT_ONE;
        end
      end

      S_START: begin
        if (cnt_q == c_HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A line that is high again at mid-start is a glitch. No frame.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {shift_q[6:0], rx_s_q};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == c_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: the data bits and the parity bit must XOR to 0.
            if (par_q ^ (^shift_q)) begin
              perr_d = 1'b1;
            end else begin
              dout_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            dout_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            // A bad stop bit outranks a parity error. Wait for the line to
            // go high so a break is not taken as a new start bit.
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_ONE;
        end
      end

      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign data_out      = dout_q;
  assign data_valid    = valid_q;
  assign framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`endif
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sipo
// Description : Self-checking bench for uart_rx_sipo. It drives directed and
//               random frames, predicts one status pulse per frame from the
//               frame contents, and compares the pulse kind, pulse timing
//               and data_out against that prediction.
//               It honours UART_RX_PARITY_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sipo;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_K = 10;
`else
  localparam int STOP_K = 9;
`endif
  localparam int FRAME_BITS = STOP_K + 1;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;
  logic       perr_w;

  uart_rx_sipo #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .framing_error(framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error (perr_w),
`endif
    .busy         (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  // One expected pulse per frame. hold is the data_out value that must
  // still be present when the frame is rejected.
  typedef struct {
    int         kind;
    logic [7:0] data;
    logic [7:0] hold;
    int         when;
  } ev_t;

  ev_t        exp_q[$];
  int         valid_cyc[$];
  logic [7:0] exp_dout = 8'h00;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one frame, starting at a negedge. The expected pulse is the
  // synchronizer delay (2 edges, where rx_s falls 1 edge after the line
  // edge), plus HALF, plus STOP_K bit periods after the line edge.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par_bad, input int gap);
    ev_t e;
    e.data = d;
    e.hold = exp_dout;
    e.when = (cyc + 1) + 1 + HALF + STOP_K * CPB;
    if (!stop)        e.kind = K_FERR;
    else if (par_bad) e.kind = K_PERR;
    else              e.kind = K_VALID;
    if (e.kind == K_VALID) exp_dout = d;
    exp_q.push_back(e);

    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_bad;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    if (gap > 0) begin
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  // Pulse monitor: every pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    ev_t        e;
    logic [2:0] exp_vec;
    if (data_valid || framing_error || perr_w) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", 32'({data_valid, framing_error, perr_w}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        exp_vec = (e.kind == K_VALID) ? 3'b100 : ((e.kind == K_FERR) ? 3'b010 : 3'b001);
        check_eq("pulse_kind", 32'({data_valid, framing_error, perr_w}), 32'(exp_vec));
        check_eq("pulse_time", 32'(cyc >= e.when - 1 && cyc <= e.when + 1), 32'd1);
        if (e.kind == K_VALID) begin
          check_eq("pulse_data", 32'(data_out), 32'(e.data));
          valid_cyc.push_back(cyc);
        end else begin
          check_eq("pulse_hold", 32'(data_out), 32'(e.hold));
        end
      end
    end
  end

  initial begin
    int         bc;
    logic [7:0] d;
    logic       stop;
    logic       pb;
    int         gap;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", 32'(data_out), 32'h00);
    check_eq("rst_valid", 32'(data_valid), 32'd0);
    check_eq("rst_ferr", 32'(framing_error), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // A start glitch that is 4 cycles wide.
    bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clk);
      if (busy) bc++;
    end
    check_eq("glitch_busy_short", 32'(bc > 0 && bc < 8), 32'd1);
    check_eq("glitch_data_out", 32'(data_out), 32'h00);

    // A single good frame.
    send_frame(8'hA5, 1'b1, 1'b0, 20);
    check_eq("a5_busy_idle", 32'(busy), 32'd0);
    check_eq("a5_data_out", 32'(data_out), 32'hA5);

    // A bad stop bit, followed by a held-low line.
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    repeat (40) @(negedge clk);
    check_eq("ferr_busy_while_low", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("ferr_busy_released", 32'(busy), 32'd0);
    check_eq("ferr_data_kept", 32'(data_out), 32'hA5);

    // Back-to-back frames.
    valid_cyc.delete();
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 20);
    check_eq("b2b_count", 32'(valid_cyc.size()), 32'd2);
    check_eq("b2b_spacing", 32'((valid_cyc.size() == 2) ? valid_cyc[1] - valid_cyc[0] : 0),
             32'(CPB * FRAME_BITS));
    check_eq("b2b_data_out", 32'(data_out), 32'hC3);

    // Random frames, with occasional bad stop bits and bad parity.
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      pb   = ($urandom_range(0, 3) == 0);
`else
      pb   = 1'b0;
`endif
      gap  = stop ? $urandom_range(0, 12) : $urandom_range(3, 12);
      send_frame(d, stop, pb, gap);
    end
    repeat (5) @(negedge clk);
    check_eq("rand_data_out", 32'(data_out), 32'(exp_dout));

    // Reset in the middle of a 0xFF frame, after 3 data bits.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_rst_data_out", 32'(data_out), 32'h00);
    check_eq("abort_rst_valid", 32'(data_valid), 32'd0);
    check_eq("abort_rst_ferr", 32'(framing_error), 32'd0);
    check_eq("abort_rst_busy", 32'(busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    check_eq("abort_rst_perr", 32'(perr_w), 32'd0);
`endif
    exp_dout = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_eq("abort_idle_after", 32'(busy), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 20);
    check_eq("abort_5a_data_out", 32'(data_out), 32'h5A);

`ifdef UART_RX_PARITY_EN
    // Wrong parity first, then correct parity.
    send_frame(8'hA5, 1'b1, 1'b1, 20);
    check_eq("par_bad_data_kept", 32'(data_out), 32'h5A);
    send_frame(8'hA5, 1'b1, 1'b0, 20);
    check_eq("par_good_data_out", 32'(data_out), 32'hA5);
`endif

    repeat (50) @(negedge clk);
    check_eq("missing_pulses", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
- UART receive path: serial-in, parallel-out deserializer with a start-bit detector, mid-bit sampler and stop-bit check.
- Pairs with the transmitter's shift-out stage. Frame format: 1 start bit (0), 8 data bits MSB first, [optional parity], 1 stop bit (1).
- Sits between the rx pad and the receive-side consumer (FIFO or host register). The consumer sees one byte plus a status pulse per frame.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per bit period; integer, >= 4.
- HALF_BIT, CLKS_PER_BIT/2, offset from the start edge to the first sample point; derived, do not override.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk, idles high.
- data_out  output  8  last correctly framed byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out updates.
- framing_error  output  1  one-cycle pulse when the stop bit is sampled 0.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, reset=0):
  - All outputs 0; data_out=8'h00.
  - Shift register and counters cleared.
  - 2-FF rx synchronizer preset to 1.
  - FSM forced to IDLE.
  - Assertion mid-frame abandons the frame with no pulses generated.
- Synchronizer: rx passes through 2 flops, giving 2 cycles of latency. All decisions use the synchronized value rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; plus PARITY when the optional feature is compiled in.
- IDLE:
  - Go to START when rx_s==0.
  - Clear the bit counter (cnt) and bit index (idx).
- START:
  - cnt counts up to HALF_BIT-1.
  - At that count, sample rx_s. If 0, go to DATA with cnt=0, idx=0. If 1, treat it as a glitch and return to IDLE; no pulse.
- DATA:
  - cnt counts up to CLKS_PER_BIT-1, then samples: shift <= {shift[6:0], rx_s}; cnt=0; idx++.
  - After the sample with idx==7, go to STOP (or to PARITY if enabled).
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - If 1: data_out<=shift, data_valid=1 for one cycle, go to IDLE.
  - If 0: framing_error=1 for one cycle, data_out unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from being read as a new start bit.
- Sample points fall at HALF_BIT + k*CLKS_PER_BIT cycles after the synchronized falling edge, for k=1..9 (k=9 is the stop bit).
- data_valid / framing_error rise on the clock edge at the stop sample point.
- Back-to-back frames: returning to IDLE in the stop sample cycle lets a start edge in the very next cycle be detected. No dead time beyond one cycle.
- data_valid and framing_error are never high in the same cycle.
- busy: combinational decode of state!=IDLE, registered state only.
- Counter widths: cnt is $clog2(CLKS_PER_BIT) bits; idx is 3 bits. Neither ever exceeds its terminal value.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state between DATA and STOP and the output port parity_error (1 bit, reset 0).
  - Even parity: the sampled parity bit is XOR-checked against ^shift.
  - At the stop sample, a good stop bit with a parity mismatch gives parity_error=1 for one cycle, data_valid=0, and data_out unchanged.
  - A bad stop bit gives framing_error only; it takes priority over parity.
  - Frame length becomes 11 bits.
- Undefined: no PARITY state, no parity_error port, 10-bit frame.

Test Plan:
- CLKS_PER_BIT=16; drive frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> data_out=8'hA5, data_valid high exactly 1 cycle, framing_error=0, busy low after the stop sample.
- rx low for 4 cycles, then high -> busy for less than 8 cycles, returns to IDLE, no data_valid, data_out still 8'h00.
- Frame 0x3C with stop bit driven 0, line held low 40 cycles, then high -> framing_error 1-cycle pulse, data_out keeps its prior value, busy stays high until rx_s returns to 1.
- Frames 0x3C and 0xC3 back-to-back, with the second start bit immediately after the first stop bit -> two data_valid pulses 160 cycles apart, values 8'h3C then 8'hC3.
- reset pulsed low after 3 data bits of 0xFF, then frame 0x5A -> all outputs 0 during reset, no pulse for the aborted frame, then data_out=8'h5A with data_valid.
- With UART_RX_PARITY_EN, frame 0xA5 with parity bit 1 (wrong; correct is 0) -> parity_error pulse, no data_valid. Repeat with parity bit 0 -> data_valid, data_out=8'hA5.
